// File: rtl/vga_timing_gen_pkg.sv
// vga_pkg: default 640x480@60 raster constants, derived totals and sync
// windows, output widths, and a small window-decode helper shared by the
// timing generator.
package vga_pkg;

    // Default timing in pixels / lines
    localparam int CLK_DIV_DEF  = 2;
    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;

    // Derived raster geometry for the defaults
    localparam int H_TOTAL  = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
    localparam int V_TOTAL  = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;
    localparam int HS_START = H_ACTIVE_DEF + H_FP_DEF;
    localparam int HS_END   = HS_START + H_SYNC_DEF - 1;
    localparam int VS_START = V_ACTIVE_DEF + V_FP_DEF;
    localparam int VS_END   = VS_START + V_SYNC_DEF - 1;

    // Widths
    localparam int X_W     = 10;
    localparam int Y_W     = 9;
    localparam int H_CNT_W = 10;
    localparam int V_CNT_W = 10;
    localparam int DIV_W   = 4;
    localparam int FRAME_W = 16;

    // True when val lies in the inclusive window [lo, hi]
    function automatic logic in_window(input logic [9:0] val,
                                       input logic [9:0] lo,
                                       input logic [9:0] hi);
        return (val >= lo) && (val <= hi);
    endfunction

endpackage

// File: rtl/vga_timing_gen_pix_strobe_div.sv
// pix_strobe_div: divides the board clock into a one-clock strobe every
// CLK_DIV clocks. With CLK_DIV=1 the strobe is permanently high.
module pix_strobe_div
    import vga_pkg::*;
#(
    parameter int CLK_DIV = CLK_DIV_DEF
) (
    input  logic clk_in,
    input  logic i_rst,
    output logic o_stb
);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_cnt;

    // Free-running divider, wraps after CLK_DIV clocks
    always_ff @(posedge clk_in or negedge i_rst) begin
        if (!i_rst) begin
            div_cnt <= '0;
        end else if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    assign o_stb = (div_cnt == DIV_LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster timing (sync, active, clamped coordinates, per-frame
// animate strobe). Define VGA_FRAME_CNT_EN to build the 16-bit frame counter
// on o_frame; otherwise o_frame is tied to zero.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int CLK_DIV  = CLK_DIV_DEF,
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF
) (
    input  logic               clk_in,
    input  logic               i_rst,
    output logic               o_pix_stb,
    output logic               o_hs,
    output logic               o_vs,
    output logic               o_active,
    output logic [X_W-1:0]     o_x,
    output logic [Y_W-1:0]     o_y,
    output logic               o_animate,
    output logic [FRAME_W-1:0] o_frame
);

    localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [H_CNT_W-1:0] H_LAST   = H_CNT_W'(H_TOT - 1);
    localparam logic [V_CNT_W-1:0] V_LAST   = V_CNT_W'(V_TOT - 1);
    localparam logic [H_CNT_W-1:0] X_MAX    = H_CNT_W'(H_ACTIVE - 1);
    localparam logic [V_CNT_W-1:0] Y_MAX    = V_CNT_W'(V_ACTIVE - 1);
    localparam logic [H_CNT_W-1:0] HS_FIRST = H_CNT_W'(H_ACTIVE + H_FP);
    localparam logic [H_CNT_W-1:0] HS_LAST  = H_CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [V_CNT_W-1:0] VS_FIRST = V_CNT_W'(V_ACTIVE + V_FP);
    localparam logic [V_CNT_W-1:0] VS_LAST  = V_CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

    // Column saturated to the last visible pixel
    function automatic logic [X_W-1:0] sat_x(input logic [H_CNT_W-1:0] h);
        return (h > X_MAX) ? X_W'(X_MAX) : X_W'(h);
    endfunction

    // Row saturated to the last visible line, narrowed only after clamping
    function automatic logic [Y_W-1:0] sat_y(input logic [V_CNT_W-1:0] v);
        logic [V_CNT_W-1:0] c;
        c = (v > Y_MAX) ? Y_MAX : v;
        return Y_W'(c);
    endfunction

    logic               stb_p0;
    logic [H_CNT_W-1:0] h_cnt_p0;
    logic [V_CNT_W-1:0] v_cnt_p0;

    logic               hs_d;
    logic               vs_d;
    logic               active_d;
    logic [X_W-1:0]     x_d;
    logic [Y_W-1:0]     y_d;
    logic               anim_d;

    logic               vld_p1;
    logic               hs_p1;
    logic               vs_p1;
    logic               active_p1;
    logic [X_W-1:0]     x_p1;
    logic [Y_W-1:0]     y_p1;
    logic               anim_p1;

    pix_strobe_div #(
        .CLK_DIV (CLK_DIV)
    ) u_div (
        .clk_in (clk_in),
        .i_rst  (i_rst),
        .o_stb  (stb_p0)
    );

    // ---- stage p0: raster position counters ----

    // Advance column each pixel strobe; bump the line on column wrap
    always_ff @(posedge clk_in or negedge i_rst) begin
        if (!i_rst) begin
            h_cnt_p0 <= '0;
            v_cnt_p0 <= '0;
        end else if (stb_p0) begin
            if (h_cnt_p0 == H_LAST) begin
                h_cnt_p0 <= '0;
                v_cnt_p0 <= (v_cnt_p0 == V_LAST) ? '0 : v_cnt_p0 + 1'b1;
            end else begin
                h_cnt_p0 <= h_cnt_p0 + 1'b1;
            end
        end
    end

    // Decode the current (pre-increment) position into display signals
    always_comb begin
        hs_d     = !in_window(h_cnt_p0, HS_FIRST, HS_LAST);
        vs_d     = !in_window(v_cnt_p0, VS_FIRST, VS_LAST);
        active_d = (h_cnt_p0 <= X_MAX) && (v_cnt_p0 <= Y_MAX);
        x_d      = sat_x(h_cnt_p0);
        y_d      = sat_y(v_cnt_p0);
        anim_d   = (h_cnt_p0 == X_MAX) && (v_cnt_p0 == Y_MAX);
    end

    // ---- stage p1: registered outputs ----

    // Capture decoded pixel on strobe and hold it until the next one
    always_ff @(posedge clk_in or negedge i_rst) begin
        if (!i_rst) begin
            vld_p1    <= 1'b0;
            anim_p1   <= 1'b0;
            hs_p1     <= 1'b1;
            vs_p1     <= 1'b1;
            active_p1 <= 1'b0;
            x_p1      <= '0;
            y_p1      <= '0;
        end else begin
            vld_p1  <= stb_p0;
            anim_p1 <= stb_p0 && anim_d;
            if (stb_p0) begin
                hs_p1     <= hs_d;
                vs_p1     <= vs_d;
                active_p1 <= active_d;
                x_p1      <= x_d;
                y_p1      <= y_d;
            end
        end
    end

`ifdef VGA_FRAME_CNT_EN
    logic [FRAME_W-1:0] frame_p1;

    // Count frames, stepping together with the animate pulse
    always_ff @(posedge clk_in or negedge i_rst) begin
        if (!i_rst) begin
            frame_p1 <= '0;
        end else if (stb_p0 && anim_d) begin
            frame_p1 <= frame_p1 + 1'b1;
        end
    end

    assign o_frame = frame_p1;
`else
    assign o_frame = '0;
`endif

    assign o_pix_stb = vld_p1;
    assign o_hs      = hs_p1;
    assign o_vs      = vs_p1;
    assign o_active  = active_p1;
    assign o_x       = x_p1;
    assign o_y       = y_p1;
    assign o_animate = anim_p1;

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Generates the 640x480 @ 60 Hz VGA raster timing that drives the display-side blocks: horizontal/vertical sync, active-area flag, current pixel coordinates and a once-per-frame animation strobe. It sits between the board clock and every pixel consumer: ball renderer, bar renderers and colour mux. All consumers sample its outputs on `o_pix_stb` and update game state on `o_animate`.

## Interface

Parameters:
- `CLK_DIV`, 2: board clocks per pixel; 2 gives 25 MHz pixel rate from 50 MHz. Legal range 1..15.
- `H_ACTIVE`, 640: visible pixels per line.
- `H_FP`, 16: horizontal front porch.
- `H_SYNC`, 96: horizontal sync width.
- `H_BP`, 48: horizontal back porch.
- `V_ACTIVE`, 480: visible lines.
- `V_FP`, 10: vertical front porch.
- `V_SYNC`, 2: vertical sync width.
- `V_BP`, 33: vertical back porch.

Ports:
- `clk_in`  in  1  board clock.
- `i_rst`  in  1  reset, asynchronous, active-low.
- `o_pix_stb`  out  1  one-`clk_in` pulse; all other outputs are valid and new on this cycle.
- `o_hs`  out  1  horizontal sync, active-low.
- `o_vs`  out  1  vertical sync, active-low.
- `o_active`  out  1  high while the current pixel is inside 640x480.
- `o_x`  out  10  current column, clamped to 0..639.
- `o_y`  out  9  current row, clamped to 0..479.
- `o_animate`  out  1  one-`clk_in` pulse per frame at end of active area.
- `o_frame`  out  16  frame counter; see Configuration.

## Operation

- Strobe divider: `div_cnt` counts 0..CLK_DIV-1, wraps to 0. Internal strobe `stb` is high when `div_cnt == CLK_DIV-1`. With CLK_DIV=1, `stb` is constant high after reset.
- Counters advance only on `stb`.
  - `h_cnt` runs 0..799 (H_TOTAL = sum of the horizontal parameters) and wraps to 0.
  - On `h_cnt` wrap, `v_cnt` increments over 0..524 (V_TOTAL) and wraps to 0.
- Decode, using the counter values before the increment:
  - `o_hs` = 0 iff `h_cnt` is in [656,751].
  - `o_vs` = 0 iff `v_cnt` is in [490,491].
  - `o_active` = (`h_cnt` < 640) && (`v_cnt` < 480).
  - `o_x` = min(`h_cnt`, 639); `o_y` = min(`v_cnt`, 479).
  - `o_animate` = 1 iff `h_cnt`==639 && `v_cnt`==479.
- Outputs are registered. They update only on the cycle after `stb` and hold between strobes. `o_pix_stb` is the registered `stb`. `o_animate` is gated by that strobe, so it is high for exactly 1 `clk_in` per frame.
- Widths: comparisons are done at counter width (10 bits h, 10 bits v). `o_y` is truncated to 9 bits only after clamping.

## Timing

- Reset while `i_rst`=0, asynchronous and applicable mid-frame:
  - `div_cnt`=0, `h_cnt`=0, `v_cnt`=0.
  - `o_hs`=1, `o_vs`=1, `o_active`=0, `o_x`=0, `o_y`=0, `o_pix_stb`=0, `o_animate`=0, `o_frame`=0.
- After reset release: the first `stb` occurs at clock CLK_DIV-1. On the next cycle, outputs show pixel (0,0) with `o_active`=1 and `o_pix_stb`=1.
- Latency: one `clk_in` from the counter state to the outputs.
- Pixel period: CLK_DIV clocks. Line: 800 pixels. Frame: 420000 pixels, i.e. 840000 clocks at CLK_DIV=2.
- Line wrap and frame wrap happen on the same `stb`. Both counters go to 0 together, with no extra cycle.
- `o_animate` and `o_pix_stb` are asserted in the same cycle. Consumers see `o_x`=639, `o_y`=479, `o_active`=1 on that cycle.

## Configuration

- `VGA_FRAME_CNT_EN` defined: `o_frame` increments by 1 (mod 2^16) on the cycle `o_animate` is asserted.
- `VGA_FRAME_CNT_EN` undefined: `o_frame` is tied to 0 and the counter is not synthesised. The port stays present in both builds.

## Structure

- Package `vga_pkg` holds:
  - the default timing constants;
  - derived H_TOTAL, V_TOTAL, HS_START, HS_END, VS_START, VS_END;
  - the coordinate widths X_W=10, Y_W=9.
- The parameters above default from `vga_pkg`.
- Sub-module `pix_strobe_div` (parameter CLK_DIV; ports `clk_in`, `i_rst`, `o_stb`) holds the divider and is reused by the audio tick logic.

## Test plan

- Reset released, CLK_DIV=2 -> first `o_pix_stb` at clock 2 after release, with `o_x`=0, `o_y`=0, `o_active`=1, `o_hs`=1, `o_vs`=1.
- Run one line -> `o_hs` low for exactly 96 strobes starting at pixel 656. `o_active` falls after `o_x`=639. `o_x` holds 639 through blanking.
- Run one frame -> `o_vs` low for lines 490-491 only (1600 strobes). Exactly one `o_animate` pulse, 1 clock wide, with `o_x`=639 and `o_y`=479. Next frame starts 840000 clocks after the previous one.
- `i_rst` asserted at pixel (300,200) for 3 clocks -> all outputs at reset values immediately. After release, the raster restarts at (0,0).
- `VGA_FRAME_CNT_EN` defined, run 3 frames -> `o_frame` reads 1, 2, 3 after each `o_animate`. Undefined -> `o_frame` stays 0.
- CLK_DIV=1 -> `o_pix_stb` continuously high. Frame length is 420000 clocks. Sync positions are unchanged in pixel units.
